// File: rtl/wash_phase_timer.sv
// Washing-machine phase sequencer: FILL -> WASH -> RINSE [-> WASH -> RINSE] -> SPIN -> IDLE.
// Each phase lasts a whole number of seconds. Define DOOR_LOCK_EN to add a registered door_lock output.
module wash_phase_timer #(
   parameter int SEC_CYCLES_1X = 1000000,
   parameter int FILL_SEC      = 120,
   parameter int WASH_SEC      = 300,
   parameter int RINSE_SEC     = 120,
   parameter int SPIN_SEC      = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] clk_freq,
   input  logic       coin_in,
   input  logic       double_wash,
   input  logic       timer_pause,
   output logic [2:0] phase,
`ifdef DOOR_LOCK_EN
   output logic       wash_done,
   output logic       door_lock
`else
   output logic       wash_done
`endif
);

   localparam int PW = $clog2(SEC_CYCLES_1X * 8);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      SPIN  = 3'd4
   } state_t;

   state_t        state, nxt;
   logic [PW-1:0] presc, term;
   logic [8:0]    secs, dur;
   logic [1:0]    freq_lat;
   logic          dw_lat, pass_flag;
   logic          start, hold, sec_tick, phase_end;

   assign phase = state;

   always_comb begin
      term      = PW'((SEC_CYCLES_1X << freq_lat) - 1);
      dur       = 9'd1;
      nxt       = state;
      start     = 1'b0;
      case (state)
         FILL:    dur = 9'(FILL_SEC);
         WASH:    dur = 9'(WASH_SEC);
         RINSE:   dur = 9'(RINSE_SEC);
         SPIN:    dur = 9'(SPIN_SEC);
         default: dur = 9'd1;
      endcase
      // pause only freezes the spin phase; elsewhere it is ignored
      hold      = (state == SPIN) && timer_pause;
      sec_tick  = (state != IDLE) && !hold && (presc == term);
      phase_end = sec_tick && (secs == dur - 9'd1);
      case (state)
         IDLE: if (coin_in) begin
            nxt   = FILL;
            start = 1'b1;
         end
         FILL:  if (phase_end) nxt = WASH;
         WASH:  if (phase_end) nxt = RINSE;
         RINSE: if (phase_end) nxt = (dw_lat && !pass_flag) ? WASH : SPIN;
         SPIN:  if (phase_end) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         secs      <= '0;
         freq_lat  <= '0;
         dw_lat    <= 1'b0;
         pass_flag <= 1'b0;
         wash_done <= 1'b0;
      end else begin
         // every state entry restarts the phase timing from zero
         if (start || phase_end) begin
            presc <= '0;
            secs  <= '0;
         end else if (sec_tick) begin
            presc <= '0;
            secs  <= secs + 9'd1;
         end else if (state != IDLE && !hold) begin
            presc <= presc + 1'b1;
         end
         if (start) begin
            freq_lat  <= clk_freq;
            dw_lat    <= double_wash;
            wash_done <= 1'b0;
         end
         if (state == RINSE && phase_end && dw_lat && !pass_flag)
            pass_flag <= 1'b1;
         if (state == SPIN && phase_end) begin
            pass_flag <= 1'b0;
            wash_done <= 1'b1;
         end
      end
   end

`ifdef DOOR_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) door_lock <= 1'b0;
      else        door_lock <= (nxt != IDLE);
   end
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: stimulus queues expected phase entries, a monitor checks them.
module tb_wash_phase_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] clk_freq = 2'b00;
   logic       coin_in = 1'b0;
   logic       double_wash = 1'b0;
   logic       timer_pause = 1'b0;
   logic [2:0] phase;
   logic       wash_done;

   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic [2:0]  ph;
      logic        wd;
      int unsigned cy;
   } exp_t;

   exp_t q[$];

   wash_phase_timer #(
      .SEC_CYCLES_1X(4), .FILL_SEC(2), .WASH_SEC(3), .RINSE_SEC(2), .SPIN_SEC(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .coin_in(coin_in),
      .double_wash(double_wash), .timer_pause(timer_pause),
      .phase(phase), .wash_done(wash_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   function automatic void push(logic [2:0] ph, logic wd, int unsigned cy);
      exp_t e;
      e.ph = ph; e.wd = wd; e.cy = cy;
      q.push_back(e);
   endfunction

   // Pushes a normal single-pass sequence starting at t0 with period p cycles per second.
   function automatic void push_normal(int unsigned t0, int unsigned p);
      push(3'd1, 1'b0, t0);
      push(3'd2, 1'b0, t0 + 2*p);
      push(3'd3, 1'b0, t0 + 5*p);
      push(3'd4, 1'b0, t0 + 7*p);
      push(3'd0, 1'b1, t0 + 8*p);
   endfunction

   // Monitor: every phase change is popped against the scoreboard.
   initial begin
      logic [2:0] prev;
      exp_t e;
      prev = 3'd0;
      forever begin
         @(negedge clk);
         if (phase !== prev) begin
            if (q.size() == 0) begin
               chk("unexpected_phase_change", int'(phase), int'(prev));
            end else begin
               e = q.pop_front();
               chk("phase", int'(phase), int'(e.ph));
               chk("wash_done", int'(wash_done), int'(e.wd));
               chk("entry_cycle", int'(cyc), int'(e.cy));
            end
            prev = phase;
         end
      end
   end

   task automatic start(input logic [1:0] f, input logic dw, input logic keep_coin,
                        output int unsigned t0);
      @(negedge clk);
      clk_freq    = f;
      double_wash = dw;
      coin_in     = 1'b1;
      t0          = cyc + 1;
      @(posedge clk);
      #1;
      if (!keep_coin) coin_in = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int unsigned t0;
      #2;
      chk("reset_phase", int'(phase), 0);
      chk("reset_wash_done", int'(wash_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_without_coin", int'(phase), 0);

      // nominal run, coin held through FILL and WASH must not restart
      start(2'b00, 1'b0, 1'b1, t0);
      push_normal(t0, 4);
      repeat (21) @(posedge clk);
      #1 coin_in = 1'b0;
      drain(100);
      chk("done_held_in_idle", int'(wash_done), 1);

      // 8x clock, freq and double_wash changes after start are ignored
      start(2'b11, 1'b0, 1'b0, t0);
      push_normal(t0, 32);
      clk_freq    = 2'b00;
      double_wash = 1'b1;
      drain(400);
      double_wash = 1'b0;

      // double wash: exactly two WASH passes
      start(2'b00, 1'b1, 1'b0, t0);
      double_wash = 1'b0;
      push(3'd1, 1'b0, t0);
      push(3'd2, 1'b0, t0 + 8);
      push(3'd3, 1'b0, t0 + 20);
      push(3'd2, 1'b0, t0 + 28);
      push(3'd3, 1'b0, t0 + 40);
      push(3'd4, 1'b0, t0 + 48);
      push(3'd0, 1'b1, t0 + 52);
      drain(200);

      // pause ignored in WASH, freezes SPIN for 10 cycles
      start(2'b00, 1'b0, 1'b0, t0);
      push(3'd1, 1'b0, t0);
      push(3'd2, 1'b0, t0 + 8);
      push(3'd3, 1'b0, t0 + 20);
      push(3'd4, 1'b0, t0 + 28);
      push(3'd0, 1'b1, t0 + 42);
      repeat (10) @(posedge clk);
      #1 timer_pause = 1'b1;
      repeat (5) @(posedge clk);
      #1 timer_pause = 1'b0;
      repeat (14) @(posedge clk);
      #1 timer_pause = 1'b1;
      repeat (10) @(posedge clk);
      #1 timer_pause = 1'b0;
      drain(100);

      // reset in IDLE clears wash_done at once
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_clears_done", int'(wash_done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-WASH
      start(2'b00, 1'b0, 1'b1, t0);
      push(3'd1, 1'b0, t0);
      push(3'd2, 1'b0, t0 + 8);
      repeat (13) @(posedge clk);
      #2;
      coin_in = 1'b0;
      push(3'd0, 1'b0, cyc);
      rst_n = 1'b0;
      #1;
      chk("async_reset_phase", int'(phase), 0);
      chk("async_reset_done", int'(wash_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_reset", int'(phase), 0);
      drain(20);

      // normal operation resumes after reset
      start(2'b00, 1'b0, 1'b0, t0);
      push_normal(t0, 4);
      drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
